// File: rtl/alu_issue_wb.sv
// alu_issue_wb: serialized operand-issue / writeback sequencer for the clocked ALU.
// Owns the integer register file and keeps one R/I-type instruction in flight at a time.
module alu_issue_wb #(
  parameter int n    = 32,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inst_valid,
  output logic         inst_ready,
  input  logic [31:0]  inst,
  output logic [n-1:0] alu_rs1,
  output logic [n-1:0] alu_rs2,
  output logic [31:0]  alu_inst,
  input  logic [n-1:0] alu_res,
  input  logic         alu_zf,
  output logic         done,
  output logic         illegal,
  output logic [4:0]   rd_wb,
  output logic [n-1:0] wb_data,
  output logic         wb_zf,
  input  logic [4:0]   dbg_addr,
  output logic [n-1:0] dbg_data
);
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {IDLE, ISSUE, WB, ILL} state_t;

  state_t       state_q, state_d;
  logic [n-1:0] rf_q [NREG];
  logic [n-1:0] rf_d [NREG];
  logic [n-1:0] alu_rs1_q, alu_rs1_d;
  logic [n-1:0] alu_rs2_q, alu_rs2_d;
  logic [31:0]  alu_inst_q, alu_inst_d;
  logic [n-1:0] rs1_val, rs2_val;
  logic [4:0]   wb_rd;
  logic         accept;
  logic         legal;

  assign inst_ready = (state_q == IDLE) && !rst;
  assign accept     = inst_valid && inst_ready;
  assign legal      = (inst[6:0] == OP_REG) || (inst[6:0] == OP_IMM);
  assign wb_rd      = alu_inst_q[11:7];

  // x0 and any index beyond the implemented file read as zero.
  always_comb begin
    rs1_val  = '0;
    rs2_val  = '0;
    dbg_data = '0;
    if (inst[19:15] != 5'd0 && int'(inst[19:15]) < NREG) rs1_val = rf_q[inst[19:15]];
    if (inst[24:20] != 5'd0 && int'(inst[24:20]) < NREG) rs2_val = rf_q[inst[24:20]];
    if (dbg_addr != 5'd0 && int'(dbg_addr) < NREG) dbg_data = rf_q[dbg_addr];
  end

  always_comb begin
    rf_d = rf_q;
    if (state_q == WB && wb_rd != 5'd0 && int'(wb_rd) < NREG) rf_d[wb_rd] = alu_res;
  end

  always_comb begin
    state_d    = state_q;
    alu_rs1_d  = alu_rs1_q;
    alu_rs2_d  = alu_rs2_q;
    alu_inst_d = alu_inst_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_rs1_d  = rs1_val;
          alu_rs2_d  = rs2_val;
          alu_inst_d = inst;
          state_d    = legal ? ISSUE : ILL;
        end
      end
      ISSUE:   state_d = WB;
      WB:      state_d = IDLE;
      ILL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_rs1_q  <= '0;
      alu_rs2_q  <= '0;
      alu_inst_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      alu_rs1_q  <= alu_rs1_d;
      alu_rs2_q  <= alu_rs2_d;
      alu_inst_q <= alu_inst_d;
      rf_q       <= rf_d;
    end
  end

  // Writeback outputs are gated by state so an async reset clears them at once.
  assign done     = (state_q == WB);
  assign illegal  = (state_q == ILL);
  assign rd_wb    = done ? wb_rd : 5'd0;
  assign wb_data  = done ? alu_res : '0;
  assign wb_zf    = done && alu_zf;
  assign alu_rs1  = alu_rs1_q;
  assign alu_rs2  = alu_rs2_q;
  assign alu_inst = alu_inst_q;
endmodule

// File: tb/tb_alu_issue_wb.sv
// tb_alu_issue_wb: self-checking bench for alu_issue_wb with a clocked ALU model
// and an architectural register-file reference model.
module tb_alu_issue_wb;
  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [31:0] alu_inst;
  logic [31:0] alu_res;
  logic        alu_zf;
  logic        done;
  logic        illegal;
  logic [4:0]  rd_wb;
  logic [31:0] wb_data;
  logic        wb_zf;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int          testCount;
  int          failCount;
  int          cycleCount;
  int          dutAccepts;
  logic        prevReady;
  logic [31:0] refRf [32];

  alu_issue_wb #(.n(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_inst(alu_inst),
    .alu_res(alu_res), .alu_zf(alu_zf), .done(done), .illegal(illegal),
    .rd_wb(rd_wb), .wb_data(wb_data), .wb_zf(wb_zf),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain RV32I R/I-type ALU semantics.
  function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] w);
    logic [31:0] opB;
    logic        isImm;
    isImm = (w[6:0] == 7'b0010011);
    opB   = isImm ? {{20{w[31]}}, w[31:20]} : b;
    case (w[14:12])
      3'd0:    return (!isImm && w[30]) ? a - opB : a + opB;
      3'd1:    return a << opB[4:0];
      3'd2:    return ($signed(a) < $signed(opB)) ? 32'd1 : 32'd0;
      3'd3:    return (a < opB) ? 32'd1 : 32'd0;
      3'd4:    return a ^ opB;
      3'd5:    return w[30] ? 32'($signed(a) >>> opB[4:0]) : a >> opB[4:0];
      3'd6:    return a | opB;
      default: return a & opB;
    endcase
  endfunction

  // The clocked ALU: samples operands at a posedge, result valid the next cycle.
  always @(posedge clk) begin
    alu_res <= aluRef(alu_rs1, alu_rs2, alu_inst);
    alu_zf  <= (aluRef(alu_rs1, alu_rs2, alu_inst) == 32'd0);
    cycleCount <= cycleCount + 1;
  end

  // Counts DUT-side accepts as IDLE->busy transitions seen between negedges.
  always @(negedge clk) begin
    if (prevReady && !inst_ready && !rst) dutAccepts <= dutAccepts + 1;
    prevReady <= inst_ready;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Issues one instruction starting at a negedge and returns at the negedge of
  // the following IDLE cycle, checking every cycle against the reference model.
  task automatic applyStimulus(input logic [31:0] word, input bit holdValid);
    logic [4:0]  rdIdx;
    logic [31:0] expRes;
    logic [31:0] oldRd;
    bit          legal;
    int          waitCycles;
    rdIdx  = word[11:7];
    legal  = (word[6:0] == 7'b0110011) || (word[6:0] == 7'b0010011);
    expRes = aluRef(refRf[word[19:15]], refRf[word[24:20]], word);
    oldRd  = refRf[rdIdx];
    inst       = word;
    inst_valid = 1'b1;
    dbg_addr   = rdIdx;
    waitCycles = 0;
    while (!inst_ready && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("ready_before_accept", {31'd0, inst_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (!holdValid) inst_valid = 1'b0;
    @(negedge clk);
    checkOutput("alu_inst", alu_inst, word);
    checkOutput("alu_rs1", alu_rs1, refRf[word[19:15]]);
    checkOutput("alu_rs2", alu_rs2, refRf[word[24:20]]);
    checkOutput("ready_busy", {31'd0, inst_ready}, 32'd0);
    checkOutput("done_early", {31'd0, done}, 32'd0);
    if (legal) begin
      checkOutput("illegal_on_legal", {31'd0, illegal}, 32'd0);
      @(negedge clk);
      checkOutput("done_wb", {31'd0, done}, 32'd1);
      checkOutput("rd_wb", {27'd0, rd_wb}, {27'd0, rdIdx});
      checkOutput("wb_data", wb_data, expRes);
      checkOutput("wb_zf", {31'd0, wb_zf}, {31'd0, expRes == 32'd0});
      checkOutput("dbg_old_in_wb", dbg_data, oldRd);
      checkOutput("ready_wb", {31'd0, inst_ready}, 32'd0);
      if (rdIdx != 5'd0) refRf[rdIdx] = expRes;
    end else begin
      checkOutput("illegal_pulse", {31'd0, illegal}, 32'd1);
    end
    @(negedge clk);
    checkOutput("ready_idle", {31'd0, inst_ready}, 32'd1);
    checkOutput("done_idle", {31'd0, done}, 32'd0);
    checkOutput("illegal_idle", {31'd0, illegal}, 32'd0);
    checkOutput("dbg_after", dbg_data, refRf[rdIdx]);
  endtask

  function automatic logic [31:0] randInst();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic [11:0] imm;
    int          kind;
    kind = $urandom_range(0, 9);
    rd   = 5'($urandom_range(0, 7));
    rs1  = 5'($urandom_range(0, 7));
    rs2  = 5'($urandom_range(0, 7));
    f3   = 3'($urandom_range(0, 7));
    if (kind == 0) begin
      op = 7'($urandom_range(0, 127));
      if (op == 7'b0110011 || op == 7'b0010011) op = 7'b0000011;
      return {25'($urandom), op};
    end else if (kind < 5) begin
      f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0;
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
    end
    imm = 12'($urandom);
    if (f3 == 3'd1) imm[11:5] = 7'b0;
    if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0;
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  initial begin
    int startCycle;
    int startAccepts;
    testCount  = 0;
    failCount  = 0;
    cycleCount = 0;
    dutAccepts = 0;
    prevReady  = 1'b0;
    alu_res    = '0;
    alu_zf     = 1'b0;
    for (int i = 0; i < 32; i++) refRf[i] = '0;
    rst        = 1'b1;
    inst_valid = 1'b0;
    inst       = '0;
    dbg_addr   = 5'd1;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'd0, inst_ready}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
    checkOutput("rst_rd_wb", {27'd0, rd_wb}, 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_alu_inst", alu_inst, 32'd0);
    checkOutput("rst_alu_rs1", alu_rs1, 32'd0);
    checkOutput("rst_dbg", dbg_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(32'h00500093, 1'b0);  // ADDI x1,x0,5
    checkOutput("x1_is_5", refRf[1], 32'd5);
    applyStimulus(32'h00300113, 1'b0);  // ADDI x2,x0,3
    applyStimulus(32'h002081B3, 1'b0);  // ADD x3,x1,x2
    applyStimulus(32'h40208233, 1'b0);  // SUB x4,x1,x2
    dbg_addr = 5'd3;
    #1 checkOutput("x3_is_8", dbg_data, 32'd8);
    dbg_addr = 5'd4;
    #1 checkOutput("x4_is_2", dbg_data, 32'd2);
    applyStimulus(32'h00700013, 1'b0);  // ADDI x0,x0,7
    applyStimulus(32'h00000003, 1'b0);  // illegal opcode

    // Valid held high across four dependent instructions.
    @(negedge clk);
    startCycle   = cycleCount;
    startAccepts = dutAccepts;
    applyStimulus(32'h00100313, 1'b1);  // ADDI x6,x0,1
    applyStimulus(32'h00130313, 1'b1);  // ADDI x6,x6,1
    applyStimulus(32'h006303B3, 1'b1);  // ADD x7,x6,x6
    applyStimulus(32'h00130313, 1'b1);  // ADDI x6,x6,1
    inst_valid = 1'b0;
    checkOutput("held_accepts", 32'(dutAccepts - startAccepts), 32'd4);
    checkOutput("held_cycles", 32'(cycleCount - startCycle), 32'd12);
    dbg_addr = 5'd7;
    #1 checkOutput("x7_is_4", dbg_data, 32'd4);

    // Reset pulsed during ISSUE of ADDI x5,x0,9.
    @(negedge clk);
    inst       = 32'h00900293;
    inst_valid = 1'b1;
    @(posedge clk);
    #1 inst_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_busy", {31'd0, inst_ready}, 32'd0);
    rst      = 1'b1;
    dbg_addr = 5'd1;
    #1;
    checkOutput("mid_rst_done", {31'd0, done}, 32'd0);
    checkOutput("mid_rst_illegal", {31'd0, illegal}, 32'd0);
    checkOutput("mid_rst_alu_inst", alu_inst, 32'd0);
    checkOutput("mid_rst_alu_rs1", alu_rs1, 32'd0);
    checkOutput("mid_rst_x1", dbg_data, 32'd0);
    for (int i = 0; i < 32; i++) refRf[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_done", {31'd0, done}, 32'd0);
    checkOutput("post_rst_ready", {31'd0, inst_ready}, 32'd1);
    dbg_addr = 5'd5;
    #1 checkOutput("post_rst_x5", dbg_data, 32'd0);
    @(negedge clk);
    applyStimulus(32'h00900293, 1'b0);
    checkOutput("x5_is_9", refRf[5], 32'd9);

    for (int i = 0; i < 60; i++) applyStimulus(randInst(), 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
